capture_window_ctrl: RTL and testbench



---
 rtl/capture_ctrl_pkg.sv | 15 +
 rtl/sync_hunter.sv | 58 +++++
 rtl/capture_window_ctrl.sv | 112 +++++++++++
 tb/tb_capture_window_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/capture_ctrl_pkg.sv
// rtl/capture_ctrl_pkg.sv - shared state type and constants for capture_window_ctrl
package capture_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HUNT1   = 2'd1,
    S_HUNT2   = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  localparam logic [15:0] SYNC1_DEFAULT = 16'h00AA;
  localparam logic [15:0] SYNC2_DEFAULT = 16'h0055;
  localparam int          FRAME_CNT_W   = 8;

endpackage

// File: rtl/sync_hunter.sv
// rtl/sync_hunter.sv - SYNC1/SYNC2 header detection for the HUNT1/HUNT2 states
// CAPTURE_TIMEOUT_EN adds the HUNT2 cycle-limit counter and its clock/reset ports.
module sync_hunter
  import capture_ctrl_pkg::*;
#(
  parameter int            DW      = 16,
  parameter logic [DW-1:0] SYNC1   = DW'(SYNC1_DEFAULT),
  parameter logic [DW-1:0] SYNC2   = DW'(SYNC2_DEFAULT),
  parameter int            TIMEOUT = 4
) (
`ifdef CAPTURE_TIMEOUT_EN
  input  logic          clk,
  input  logic          rst_n,
`endif
  input  state_t        state,
  input  logic [DW-1:0] dbus,
  input  logic          dvalid,
  output state_t        hunt_next,
  output logic          hdr_found,
  output logic          hunt_timeout
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("sync_hunter: TIMEOUT must be >= 1");
  end

  logic is_s1, is_s2, in_h2;

  assign is_s1     = dvalid && (dbus == SYNC1);
  assign is_s2     = dvalid && (dbus == SYNC2);
  assign in_h2     = (state == S_HUNT2);
  assign hdr_found = in_h2 && is_s2;

`ifdef CAPTURE_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tcnt;

  // A SYNC1 in HUNT2 is a fresh header start, so it restarts the count instead of expiring.
  assign hunt_timeout = in_h2 && !is_s1 && !is_s2 && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              tcnt <= '0;
    else if (!in_h2 || is_s1 || hunt_timeout) tcnt <= '0;
    else                                      tcnt <= tcnt + TW'(1);
  end
`else
  assign hunt_timeout = 1'b0;
`endif

  always_comb begin
    hunt_next = state;
    if (state == S_HUNT1 && is_s1)
      hunt_next = S_HUNT2;
    else if (in_h2 && ((dvalid && !is_s1 && !is_s2) || hunt_timeout))
      hunt_next = S_HUNT1;
  end

endmodule

// File: rtl/capture_window_ctrl.sv
// rtl/capture_window_ctrl.sv - header-triggered capture window sequencer for the capture RAM
// CAPTURE_TIMEOUT_EN enables the HUNT2 timeout inside sync_hunter.
module capture_window_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int            DW      = 16,
  parameter int            AW      = 8,
  parameter logic [DW-1:0] SYNC1   = DW'(SYNC1_DEFAULT),
  parameter logic [DW-1:0] SYNC2   = DW'(SYNC2_DEFAULT),
  parameter int            TIMEOUT = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [DW-1:0]          DBUS,
  input  logic                   DVALID,
  input  logic                   ARM,
  input  logic                   STOP,
  input  logic [AW-1:0]          LEN,
  output logic                   WREN,
  output logic [AW-1:0]          WADDR,
  output logic [DW-1:0]          WDATA,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ABORT,
  output logic [FRAME_CNT_W-1:0] FRAME_CNT
);

  state_t        state, state_d, hunt_next;
  logic          hdr_found, hunt_timeout;
  logic [AW-1:0] len_q, beat;
  logic          arm_ok, arm_zero, last_beat;
  logic          wren_d, done_d, abort_d;

  sync_hunter #(
    .DW(DW), .SYNC1(SYNC1), .SYNC2(SYNC2), .TIMEOUT(TIMEOUT)
  ) u_hunter (
`ifdef CAPTURE_TIMEOUT_EN
    .clk          (CLK),
    .rst_n        (RST_N),
`endif
    .state        (state),
    .dbus         (DBUS),
    .dvalid       (DVALID),
    .hunt_next    (hunt_next),
    .hdr_found    (hdr_found),
    .hunt_timeout (hunt_timeout)
  );

  // STOP in IDLE is a no-op but still suppresses ARM.
  assign arm_ok    = (state == S_IDLE) && ARM && !STOP && (LEN != '0);
  assign arm_zero  = (state == S_IDLE) && ARM && !STOP && (LEN == '0);
  assign last_beat = (beat == len_q - AW'(1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:           if (arm_ok) state_d = S_HUNT1;
      S_HUNT1, S_HUNT2: begin
        if (STOP)           state_d = S_IDLE;
        else if (hdr_found) state_d = S_CAPTURE;
        else                state_d = hunt_next;
      end
      S_CAPTURE: begin
        if (STOP)                     state_d = S_IDLE;
        else if (DVALID && last_beat) state_d = S_IDLE;
      end
      default:                        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wren_d  = (state == S_CAPTURE) && DVALID && !STOP;
    done_d  = wren_d && last_beat;
    abort_d = ((state != S_IDLE) && STOP) || arm_zero || (hunt_timeout && !STOP);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      len_q     <= '0;
      beat      <= '0;
      WREN      <= 1'b0;
      WADDR     <= '0;
      WDATA     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ABORT     <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      WREN  <= wren_d;
      DONE  <= done_d;
      ABORT <= abort_d;
      BUSY  <= (state_d != S_IDLE);
      if (arm_ok) begin
        len_q <= LEN;
        beat  <= '0;
      end else if (wren_d) begin
        beat  <= beat + AW'(1);
      end
      if (wren_d) begin
        WADDR <= beat;
        WDATA <= DBUS;
      end
      if (done_d) FRAME_CNT <= FRAME_CNT + FRAME_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_capture_window_ctrl.sv
// tb/tb_capture_window_ctrl.sv - scoreboard bench for capture_window_ctrl
// Honours CAPTURE_TIMEOUT_EN in its reference model.
module tb_capture_window_ctrl;

  localparam logic [15:0] S1 = 16'h00AA;
  localparam logic [15:0] S2 = 16'h0055;
  localparam int          TIMEOUT = 4;

  logic        CLK = 1'b0, RST_N = 1'b0;
  logic [15:0] DBUS = '0;
  logic        DVALID = 1'b0, ARM = 1'b0, STOP = 1'b0;
  logic [7:0]  LEN = '0;
  logic        WREN, BUSY, DONE, ABORT;
  logic [7:0]  WADDR, FRAME_CNT;
  logic [15:0] WDATA;

  capture_window_ctrl #(.DW(16), .AW(8), .SYNC1(S1), .SYNC2(S2), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .DBUS(DBUS), .DVALID(DVALID), .ARM(ARM), .STOP(STOP),
    .LEN(LEN), .WREN(WREN), .WADDR(WADDR), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE),
    .ABORT(ABORT), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int   cyc;
    logic wren;
    logic done;
    logic abort;
  } ev_t;

  ev_t evq[$];
  int  n_chk = 0, n_pass = 0, cyc = 0;

  // Reference model: frame progress as plain counters and flags.
  int          m_busy = 0, m_hunt = 0, m_have1 = 0, m_tc = 0, m_len = 0, m_idx = 0;
  logic        exp_busy = 1'b0;
  logic [7:0]  exp_frame = '0, exp_waddr = '0;
  logic [15:0] exp_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_busy = 0; m_hunt = 0; m_have1 = 0; m_tc = 0; m_len = 0; m_idx = 0;
    exp_busy = 1'b0; exp_frame = '0; exp_waddr = '0; exp_wdata = '0;
    evq.delete();
  endtask

  task automatic model_step();
    ev_t e;
    e.cyc = cyc; e.wren = 1'b0; e.done = 1'b0; e.abort = 1'b0;
    if (m_busy == 0) begin
      if (ARM && !STOP) begin
        if (LEN == 0) e.abort = 1'b1;
        else begin
          m_busy = 1; m_hunt = 1; m_have1 = 0; m_tc = 0; m_len = int'(LEN); m_idx = 0;
        end
      end
    end else if (STOP) begin
      e.abort = 1'b1; m_busy = 0;
    end else if (m_hunt != 0) begin
      if (m_have1 == 0) begin
        if (DVALID && DBUS == S1) begin m_have1 = 1; m_tc = 0; end
      end else if (DVALID && DBUS == S2) begin
        m_hunt = 0;
      end else if (DVALID && DBUS == S1) begin
        m_tc = 0;
      end else begin
`ifdef CAPTURE_TIMEOUT_EN
        if (m_tc == TIMEOUT - 1) begin e.abort = 1'b1; m_have1 = 0; m_tc = 0; end
        else m_tc++;
`endif
        if (DVALID) m_have1 = 0;
      end
    end else if (DVALID) begin
      e.wren = 1'b1; exp_waddr = 8'(m_idx); exp_wdata = DBUS; m_idx++;
      if (m_idx == m_len) begin e.done = 1'b1; m_busy = 0; exp_frame = exp_frame + 8'd1; end
    end
    exp_busy = (m_busy != 0);
    if (e.wren || e.done || e.abort) evq.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    cyc++;
    if (RST_N) model_step();
    #1;
  endtask

  task automatic drive(input logic arm, input logic stop, input logic [7:0] len,
                       input logic v, input logic [15:0] d);
    ARM = arm; STOP = stop; LEN = len; DVALID = v; DBUS = d;
    step();
    ARM = 1'b0; STOP = 1'b0; DVALID = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d);
    drive(1'b0, 1'b0, 8'd0, 1'b1, d);
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (evq.size() != 0 && evq[0].cyc == cyc) begin
        ev_t e;
        e = evq.pop_front();
        chk("wren", WREN, e.wren);
        chk("done", DONE, e.done);
        chk("abort", ABORT, e.abort);
      end else begin
        chk("no_event", {WREN, DONE, ABORT}, 3'b000);
      end
      chk("busy", BUSY, exp_busy);
      chk("frame_cnt", FRAME_CNT, exp_frame);
      chk("waddr", WADDR, exp_waddr);
      chk("wdata", WDATA, exp_wdata);
    end
  end

  initial begin
    model_reset();
    step(); step();
    chk("rst_wren", WREN, 0);  chk("rst_waddr", WADDR, 0); chk("rst_wdata", WDATA, 0);
    chk("rst_busy", BUSY, 0);  chk("rst_done", DONE, 0);   chk("rst_abort", ABORT, 0);
    chk("rst_frame", FRAME_CNT, 0);
    RST_N = 1'b1;
    step();

    // Basic three-beat frame
    drive(1'b1, 1'b0, 8'd3, 1'b0, 16'h0);
    beat(16'h00AA); beat(16'h0055); beat(16'h0011); beat(16'h0022); beat(16'h0033);
    chk("frame_after_first", FRAME_CNT, 1);
    chk("busy_after_first", BUSY, 0);
    chk("done_with_last", DONE, 1);

    // Repeated SYNC1, single beat
    drive(1'b1, 1'b0, 8'd1, 1'b0, 16'h0);
    beat(16'h00AA); beat(16'h00AA); beat(16'h0055); beat(16'h0077);
    chk("waddr_len1", WADDR, 0);
    chk("wdata_len1", WDATA, 16'h0077);

    // Broken header falls back to HUNT1, then stop
    drive(1'b1, 1'b0, 8'd4, 1'b0, 16'h0);
    beat(16'h00AA); beat(16'h0012); beat(16'h0055);
    chk("busy_after_broken_hdr", BUSY, 1);
    drive(1'b0, 1'b1, 8'd0, 1'b0, 16'h0);

    // HUNT2 waiting: timeout only when the macro is set
    drive(1'b1, 1'b0, 8'd2, 1'b0, 16'h0);
    beat(16'h00AA);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'd0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 8'd0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 8'd0, 1'b0, 16'h0);

    // STOP after two of five beats; then LEN=0 arm
    drive(1'b1, 1'b0, 8'd5, 1'b0, 16'h0);
    beat(16'h00AA); beat(16'h0055); beat(16'h0101); beat(16'h0202);
    drive(1'b0, 1'b1, 8'd0, 1'b1, 16'h0303);
    step();
    drive(1'b1, 1'b0, 8'd0, 1'b0, 16'h0);
    chk("len0_abort", ABORT, 1);
    chk("len0_busy", BUSY, 0);

    // Asynchronous reset mid-capture, then restart at address 0
    drive(1'b1, 1'b0, 8'd5, 1'b0, 16'h0);
    beat(16'h00AA); beat(16'h0055); beat(16'h0A0A); beat(16'h0B0B);
    RST_N = 1'b0;
    #1;
    chk("arst_wren", WREN, 0);   chk("arst_waddr", WADDR, 0); chk("arst_wdata", WDATA, 0);
    chk("arst_busy", BUSY, 0);   chk("arst_frame", FRAME_CNT, 0);
    model_reset();
    step();
    RST_N = 1'b1;
    drive(1'b1, 1'b0, 8'd2, 1'b0, 16'h0);
    beat(16'h00AA); beat(16'h0055); beat(16'h0C0C);
    chk("restart_waddr", WADDR, 0);
    beat(16'h0D0D);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 5))
        0, 1:    d = S1;
        2, 3:    d = S2;
        default: d = 16'($urandom);
      endcase
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0, 8'($urandom_range(0, 5)),
            $urandom_range(0, 3) != 0, d);
    end

    drive(1'b0, 1'b1, 8'd0, 1'b0, 16'h0);
    step(); step();
    chk("queue_drained", evq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
